// File: rtl/pipeline_command_decoder.sv
// Byte-stream command decoder for N DSP pipelines: decodes header/payload
// frames from the SPI slave into registered one-cycle strobes and error codes.
module pipeline_command_decoder #(
  parameter int unsigned N_PIPELINES    = 2,
  parameter int unsigned N_BLOCKS       = 256,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned BW            = $clog2(N_BLOCKS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  output logic                      next,
  output logic [BW-1:0]             block_target,
  output logic [REG_ADDR_WIDTH-1:0] reg_target,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [INSTR_WIDTH-1:0]    instr_out,
  output logic [N_PIPELINES-1:0]    instr_write,
  output logic [N_PIPELINES-1:0]    reg_write,
  output logic [N_PIPELINES-1:0]    reg_commit,
  output logic [N_PIPELINES-1:0]    pipe_reset,
  input  logic [N_PIPELINES-1:0]    regfile_busy,
  output logic                      swap_req,
  output logic [3:0]                swap_target,
  input  logic                      swap_busy,
  output logic [3:0]                active_pipeline,
  output logic                      gain_write,
  output logic                      gain_sel,
  output logic                      error,
  output logic [2:0]                error_code,
  output logic                      busy
);

  localparam int unsigned DATA_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_FETCH_BLOCK, S_FETCH_REG, S_FETCH_DATA,
    S_FETCH_INSTR, S_ISSUE, S_WAIT_REG, S_WAIT_SWAP
  } state_e;

  typedef enum logic [3:0] {
    OP_WRITE_INSTR = 4'd1, OP_WRITE_REG = 4'd2, OP_COMMIT = 4'd3,
    OP_RESET_PIPE  = 4'd4, OP_SWAP      = 4'd5, OP_SET_GAIN = 4'd6
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_OPCODE = 3'd1, ERR_PIPE = 3'd2,
    ERR_TIMEOUT = 3'd3, ERR_SWAP_SAME = 3'd4
  } err_e;

  state_e                    state_q, state_d;
  logic [3:0]                op_q, op_d;
  logic [3:0]                p_q, p_d;
  logic                      next_q, next_d;
  logic [BW-1:0]             block_q, block_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic [N_PIPELINES-1:0]    instr_write_q, instr_write_d;
  logic [N_PIPELINES-1:0]    reg_write_q, reg_write_d;
  logic [N_PIPELINES-1:0]    reg_commit_q, reg_commit_d;
  logic [N_PIPELINES-1:0]    pipe_reset_q, pipe_reset_d;
  logic                      swap_req_q, swap_req_d;
  logic [3:0]                swap_target_q, swap_target_d;
  logic [3:0]                active_q, active_d;
  logic                      gain_write_q, gain_write_d;
  logic                      gain_sel_q, gain_sel_d;
  logic                      error_q, error_d;
  logic [2:0]                error_code_q, error_code_d;
  logic                      busy_q, busy_d;
  logic [3:0]                byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]             idle_cnt_q, idle_cnt_d;
  logic                      swap_first_q, swap_first_d;

  logic                      in_fetch;
  logic                      accept;
  logic [N_PIPELINES-1:0]    sel_mask;

  always_comb begin
    in_fetch = (state_q == S_FETCH_BLOCK) || (state_q == S_FETCH_REG) ||
               (state_q == S_FETCH_DATA)  || (state_q == S_FETCH_INSTR);
    accept   = in_valid && !next_q && ((state_q == S_IDLE) || in_fetch);
    sel_mask = N_PIPELINES'(1) << p_q;

    state_d       = state_q;
    op_d          = op_q;
    p_d           = p_q;
    next_d        = accept;
    block_d       = block_q;
    reg_d         = reg_q;
    data_d        = data_q;
    instr_d       = instr_q;
    instr_write_d = '0;
    reg_write_d   = '0;
    reg_commit_d  = '0;
    pipe_reset_d  = '0;
    swap_req_d    = 1'b0;
    swap_target_d = swap_target_q;
    active_d      = active_q;
    gain_write_d  = 1'b0;
    gain_sel_d    = gain_sel_q;
    error_d       = 1'b0;
    error_code_d  = error_code_q;
    byte_cnt_d    = byte_cnt_q;
    swap_first_d  = 1'b0;
    idle_cnt_d    = '0;
    if (in_fetch) idle_cnt_d = accept ? '0 : idle_cnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = in_byte[7:4];
          p_d     = in_byte[3:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        byte_cnt_d = '0;
        state_d    = S_IDLE;
        if (op_q == 4'd0 || op_q > OP_SET_GAIN) begin
          error_d      = 1'b1;
          error_code_d = ERR_OPCODE;
        end else if (op_q != OP_SET_GAIN && {28'd0, p_q} >= N_PIPELINES) begin
          error_d      = 1'b1;
          error_code_d = ERR_PIPE;
        end else begin
          case (op_q)
            OP_COMMIT:     reg_commit_d = sel_mask;
            OP_RESET_PIPE: pipe_reset_d = sel_mask;
            OP_SWAP: begin
              if (p_q == active_q) begin
                error_d      = 1'b1;
                error_code_d = ERR_SWAP_SAME;
              end else begin
                swap_req_d    = 1'b1;
                swap_target_d = p_q;
                swap_first_d  = 1'b1;
                state_d       = S_WAIT_SWAP;
              end
            end
            OP_SET_GAIN: begin
              gain_sel_d = p_q[0];
              state_d    = S_FETCH_DATA;
            end
            default: state_d = S_FETCH_BLOCK;
          endcase
        end
      end
      S_FETCH_BLOCK: begin
        if (accept) begin
          block_d    = in_byte[BW-1:0];
          byte_cnt_d = '0;
          state_d    = (op_q == OP_WRITE_REG) ? S_FETCH_REG : S_FETCH_INSTR;
        end
      end
      S_FETCH_REG: begin
        if (accept) begin
          reg_d      = in_byte[REG_ADDR_WIDTH-1:0];
          byte_cnt_d = '0;
          state_d    = S_FETCH_DATA;
        end
      end
      S_FETCH_DATA: begin
        if (accept) begin
          data_d = DATA_WIDTH'({data_q, in_byte});
          if (byte_cnt_q == 4'(DATA_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = (op_q == OP_WRITE_REG) ? S_WAIT_REG : S_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_FETCH_INSTR: begin
        if (accept) begin
          instr_d = INSTR_WIDTH'({instr_q, in_byte});
          if (byte_cnt_q == 4'(INSTR_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = S_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        if (op_q == OP_WRITE_INSTR) instr_write_d = sel_mask;
        else                        gain_write_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WAIT_REG: begin
        if (!swap_busy && (regfile_busy & sel_mask) == '0) begin
          reg_write_d = sel_mask;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_SWAP: begin
        // swap_busy may lag the request by a cycle, so the first cycle is not trusted
        if (!swap_first_q && !swap_busy) begin
          active_d = swap_target_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_fetch && !accept && idle_cnt_d == TW'(TIMEOUT_CYCLES)) begin
      state_d      = S_IDLE;
      idle_cnt_d   = '0;
      error_d      = 1'b1;
      error_code_d = ERR_TIMEOUT;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      p_q           <= '0;
      next_q        <= 1'b0;
      block_q       <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      instr_q       <= '0;
      instr_write_q <= '0;
      reg_write_q   <= '0;
      reg_commit_q  <= '0;
      pipe_reset_q  <= '0;
      swap_req_q    <= 1'b0;
      swap_target_q <= '0;
      active_q      <= '0;
      gain_write_q  <= 1'b0;
      gain_sel_q    <= 1'b0;
      error_q       <= 1'b0;
      error_code_q  <= ERR_NONE;
      busy_q        <= 1'b0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      swap_first_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      p_q           <= p_d;
      next_q        <= next_d;
      block_q       <= block_d;
      reg_q         <= reg_d;
      data_q        <= data_d;
      instr_q       <= instr_d;
      instr_write_q <= instr_write_d;
      reg_write_q   <= reg_write_d;
      reg_commit_q  <= reg_commit_d;
      pipe_reset_q  <= pipe_reset_d;
      swap_req_q    <= swap_req_d;
      swap_target_q <= swap_target_d;
      active_q      <= active_d;
      gain_write_q  <= gain_write_d;
      gain_sel_q    <= gain_sel_d;
      error_q       <= error_d;
      error_code_q  <= error_code_d;
      busy_q        <= busy_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      swap_first_q  <= swap_first_d;
    end
  end

  assign next            = next_q;
  assign block_target    = block_q;
  assign reg_target      = reg_q;
  assign data_out        = data_q;
  assign instr_out       = instr_q;
  assign instr_write     = instr_write_q;
  assign reg_write       = reg_write_q;
  assign reg_commit      = reg_commit_q;
  assign pipe_reset      = pipe_reset_q;
  assign swap_req        = swap_req_q;
  assign swap_target     = swap_target_q;
  assign active_pipeline = active_q;
  assign gain_write      = gain_write_q;
  assign gain_sel        = gain_sel_q;
  assign error           = error_q;
  assign error_code      = error_code_q;
  assign busy            = busy_q;

endmodule
